// File: rtl/muldiv_issue.sv
// muldiv_issue: EX-stage issue and hazard control for the HI/LO multiply/divide unit.
// Launches ops, stalls HI/LO instructions while the unit is occupied, returns MFHI/MFLO data.
module muldiv_issue #(
    parameter int CNT_W     = 16,
    parameter bit DIV0_SKIP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             flush,
    input  logic             hold,
    input  logic             md_busy,
    input  logic [31:0]      md_hi,
    input  logic [31:0]      md_lo,
    output logic             md_start,
    output logic             md_we,
    output logic             md_hilo,
    output logic [1:0]       md_op,
    output logic [31:0]      md_d1,
    output logic [31:0]      md_d2,
    output logic             stall,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic             div0,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SIGNED_MUL   = 2'd0;
    localparam logic [1:0] UNSIGNED_MUL = 2'd1;
    localparam logic [1:0] SIGNED_DIV   = 2'd2;
    localparam logic [1:0] UNSIGNED_DIV = 2'd3;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t     state;
    logic [1:0] op_q;
    logic [1:0] op_now;
    logic       act;
    logic       free;
    logic       issue;
    logic       is_md;
    logic       is_div;
    logic       is_mt;
    logic       is_mf;
    logic       dz;

    // RUN with busy low is free: the unit writes HI/LO on the edge busy drops.
    assign free   = (state == IDLE) || (state == RUN && !md_busy);
    assign act    = cmd_valid && !flush && !rst;
    assign issue  = act && free && !hold;

    assign is_md  = !cmd[2];
    assign is_div = !cmd[2] && cmd[1];
    assign is_mt  = cmd[2] && cmd[1];
    assign is_mf  = cmd[2] && !cmd[1];
    assign dz     = DIV0_SKIP && is_div && (rt_val == 32'd0);

    always_comb begin
        op_now = SIGNED_MUL;
        unique case (cmd[1:0])
            2'd0: op_now = SIGNED_MUL;
            2'd1: op_now = UNSIGNED_MUL;
            2'd2: op_now = SIGNED_DIV;
            2'd3: op_now = UNSIGNED_DIV;
        endcase
    end

    assign md_start = issue && is_md && !dz;
    assign div0     = issue && dz;
    assign md_we    = issue && is_mt;
    assign md_hilo  = (cmd == 3'd6);
    assign md_op    = md_start ? op_now : op_q;
    assign md_d1    = rs_val;
    assign md_d2    = rt_val;

    assign stall    = act && !free;

    // Reads are idempotent, so hold does not gate them.
    assign rd_valid = act && free && is_mf;

    always_comb begin
        rd_data = 32'd0;
        if (rd_valid) begin
            rd_data = cmd[0] ? md_lo : md_hi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= SIGNED_MUL;
            stall_cnt <= '0;
        end else begin
            if (md_start) begin
                state <= LAUNCH;
                op_q  <= op_now;
            end else begin
                case (state)
                    LAUNCH:  state <= RUN;
                    RUN:     state <= md_busy ? RUN : IDLE;
                    default: state <= IDLE;
                endcase
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// tb_muldiv_issue: directed bench with a 5-cycle muldiv unit and an occupancy model.
// The model checks every output each cycle; directed vectors pin literal results.
module tb_muldiv_issue;

    localparam logic [2:0] C_MULT  = 3'd0;
    localparam logic [2:0] C_MULTU = 3'd1;
    localparam logic [2:0] C_DIV   = 3'd2;
    localparam logic [2:0] C_DIVU  = 3'd3;
    localparam logic [2:0] C_MFHI  = 3'd4;
    localparam logic [2:0] C_MFLO  = 3'd5;
    localparam logic [2:0] C_MTHI  = 3'd6;
    localparam logic [2:0] C_MTLO  = 3'd7;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        hold;
    logic        md_busy;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_start;
    logic        md_we;
    logic        md_hilo;
    logic [1:0]  md_op;
    logic [31:0] md_d1;
    logic [31:0] md_d2;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        div0;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_issue #(.CNT_W(16), .DIV0_SKIP(1'b1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .rs_val(rs_val), .rt_val(rt_val), .flush(flush), .hold(hold),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
        .md_start(md_start), .md_we(md_we), .md_hilo(md_hilo),
        .md_op(md_op), .md_d1(md_d1), .md_d2(md_d2), .stall(stall),
        .rd_valid(rd_valid), .rd_data(rd_data), .div0(div0),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- muldiv unit: busy for LAT cycles, result on busy fall
    int          rem;
    logic [1:0]  u_op;
    logic [31:0] u_a;
    logic [31:0] u_b;

    function automatic logic [63:0] unit_res(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] r;
        int q;
        int m;
        r = 64'd0;
        case (op)
            2'd0: r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            2'd1: r = {32'd0, a} * {32'd0, b};
            2'd2: if (b != 0) begin
                q = $signed(a) / $signed(b);
                m = $signed(a) % $signed(b);
                r = {m, q};
            end
            default: if (b != 0) r = {a % b, a / b};
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            md_busy <= 1'b0;
            rem     <= 0;
            md_hi   <= 32'd0;
            md_lo   <= 32'd0;
        end else begin
            if (md_start) begin
                md_busy <= 1'b1;
                rem     <= LAT;
                u_op    <= md_op;
                u_a     <= md_d1;
                u_b     <= md_d2;
            end else if (rem != 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    md_busy <= 1'b0;
                    {md_hi, md_lo} <= unit_res(u_op, u_a, u_b);
                end
            end
            if (md_we) begin
                if (md_hilo) md_hi <= md_d1;
                else md_lo <= md_d1;
            end
        end
    end

    // ---------------- occupancy model: unit is taken if started last cycle or busy
    logic        launch_m;
    logic [15:0] cnt_m;
    logic        e_stall, e_start, e_we, e_div0, e_rdv;
    logic [31:0] e_rdata;
    logic [1:0]  e_op;

    always_comb begin
        logic act_m;
        logic free_m;
        logic go;
        logic dz;
        act_m   = cmd_valid && !flush && !rst;
        free_m  = !launch_m && !md_busy;
        go      = act_m && free_m && !hold;
        dz      = (cmd == C_DIV || cmd == C_DIVU) && rt_val == 32'd0;
        e_stall = act_m && !free_m;
        e_start = go && cmd <= C_DIVU && !dz;
        e_div0  = go && dz;
        e_we    = go && cmd >= C_MTHI;
        e_rdv   = act_m && free_m && (cmd == C_MFHI || cmd == C_MFLO);
        e_rdata = 32'd0;
        if (e_rdv) e_rdata = (cmd == C_MFHI) ? md_hi : md_lo;
        e_op = 2'd0;
        case (cmd)
            C_MULT:  e_op = 2'd0;
            C_MULTU: e_op = 2'd1;
            C_DIV:   e_op = 2'd2;
            C_DIVU:  e_op = 2'd3;
            default: e_op = 2'd0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            launch_m <= 1'b0;
            cnt_m    <= 16'd0;
        end else begin
            launch_m <= e_start;
            if (e_stall && cnt_m != 16'hFFFF) cnt_m <= cnt_m + 16'd1;
        end
    end

    logic model_on = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("stall", {31'd0, stall}, {31'd0, e_stall});
            chk("md_start", {31'd0, md_start}, {31'd0, e_start});
            chk("md_we", {31'd0, md_we}, {31'd0, e_we});
            chk("div0", {31'd0, div0}, {31'd0, e_div0});
            chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_rdv});
            chk("rd_data", rd_data, e_rdata);
            chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, cnt_m});
            chk("md_d1", md_d1, rs_val);
            chk("md_d2", md_d2, rt_val);
            if (e_start) chk("md_op", {30'd0, md_op}, {30'd0, e_op});
            if (e_we) chk("md_hilo", {31'd0, md_hilo}, {31'd0, cmd == C_MTHI});
        end
    end

    // ---------------- directed stimulus
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cmd_valid = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [31:0] rs,
                           input logic [31:0] rt, output int stalls,
                           output logic [31:0] rd, output logic st,
                           output logic we, output logic dz,
                           output logic [1:0] op);
        bit done = 0;
        cmd_valid = 1'b1;
        cmd       = c;
        rs_val    = rs;
        rt_val    = rt;
        stalls    = 0;
        rd = 32'd0; st = 1'b0; we = 1'b0; dz = 1'b0; op = 2'd0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) begin
                rd = rd_data; st = md_start; we = md_we;
                dz = div0; op = md_op;
                done = 1;
                break;
            end
            stalls++;
            tick();
        end
        if (!done) chk("stall_timeout", 32'd0, 32'd1);
        tick();
        idle();
    endtask

    int          ns;
    logic [31:0] rd;
    logic        st, we, dz;
    logic [1:0]  op;
    int          starts;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        cmd = C_MFLO; rs_val = 32'd0; rt_val = 32'd0;
        cmd_valid = 1'b1;
        model_on = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        tick();
        idle();
        rst = 1'b0;
        tick();

        // MULT 7 * -3, MFLO stalls through the unit latency
        run_cmd(C_MULT, 32'd7, 32'hFFFFFFFD, ns, rd, st, we, dz, op);
        chk("mult_start", {31'd0, st}, 32'd1);
        chk("mult_op", {30'd0, op}, 32'd0);
        run_cmd(C_MFLO, 0, 0, ns, rd, st, we, dz, op);
        chk("mult_lo", rd, 32'hFFFFFFEB);
        chk("mflo_stalls", ns, 32'd5);
        @(negedge clk);
        chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
        tick();
        run_cmd(C_MFHI, 0, 0, ns, rd, st, we, dz, op);
        chk("mult_hi", rd, 32'hFFFFFFFF);
        chk("mfhi_stalls", ns, 32'd0);

        // DIVU then MTHI back-to-back
        run_cmd(C_DIVU, 32'd100, 32'd7, ns, rd, st, we, dz, op);
        chk("divu_op", {30'd0, op}, 32'd3);
        run_cmd(C_MTHI, 32'h1234, 0, ns, rd, st, we, dz, op);
        chk("mthi_we", {31'd0, we}, 32'd1);
        chk("mthi_stalls", ns, 32'd5);
        run_cmd(C_MFHI, 0, 0, ns, rd, st, we, dz, op);
        chk("mthi_hi", rd, 32'h1234);
        run_cmd(C_MFLO, 0, 0, ns, rd, st, we, dz, op);
        chk("divu_lo", rd, 32'd14);

        // DIV by zero is suppressed
        run_cmd(C_DIV, 32'd5, 32'd0, ns, rd, st, we, dz, op);
        chk("div0_start", {31'd0, st}, 32'd0);
        chk("div0_pulse", {31'd0, dz}, 32'd1);
        run_cmd(C_MFLO, 0, 0, ns, rd, st, we, dz, op);
        chk("div0_lo", rd, 32'd14);
        chk("div0_nostall", ns, 32'd0);
        chk("div0_once", {31'd0, dz}, 32'd0);

        // MULTU under hold for 3 cycles
        starts = 0;
        cmd_valid = 1'b1; cmd = C_MULTU; rs_val = 32'd3; rt_val = 32'd5;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (md_start) starts++;
            tick();
        end
        hold = 1'b0;
        @(negedge clk);
        chk("hold_release_start", {31'd0, md_start}, 32'd1);
        if (md_start) starts++;
        tick();
        idle();
        chk("hold_starts", starts, 32'd1);
        run_cmd(C_MFLO, 0, 0, ns, rd, st, we, dz, op);
        chk("multu_lo", rd, 32'd15);

        // flushed DIV behind a running MULT
        run_cmd(C_MULT, 32'd6, 32'd7, ns, rd, st, we, dz, op);
        cmd_valid = 1'b1; cmd = C_DIV; rs_val = 32'd9; rt_val = 32'd3;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        chk("flush_start", {31'd0, md_start}, 32'd0);
        tick();
        idle();
        run_cmd(C_MFLO, 0, 0, ns, rd, st, we, dz, op);
        chk("flush_lo", rd, 32'd42);
        chk("flush_stalls", ns, 32'd4);

        // reset during RUN
        run_cmd(C_MULT, 32'd2, 32'd3, ns, rd, st, we, dz, op);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cnt_clear", {16'd0, stall_cnt}, 32'd0);
        tick();
        run_cmd(C_MTLO, 32'h55, 0, ns, rd, st, we, dz, op);
        chk("rst_mtlo_we", {31'd0, we}, 32'd1);
        chk("rst_mtlo_stalls", ns, 32'd0);
        run_cmd(C_MFLO, 0, 0, ns, rd, st, we, dz, op);
        chk("rst_lo", rd, 32'h55);

        tick();
        tick();
        model_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_issue.md
Name: muldiv_issue

Overview:
- EX-stage issue/hazard controller that sits directly upstream of the multiply/divide unit.
- Decodes the HI/LO instruction class from ID/EX and drives that unit's start/we/op/operand inputs.
- Tracks the unit's in-flight operation, raises a pipeline stall for any HI/LO instruction that arrives while the unit is occupied, and returns MFHI/MFLO data to the EX result mux.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- DIV0_SKIP, 1, when 1 a DIV/DIVU with rt==0 is not launched (HI/LO unchanged) and div0 pulses.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  ID/EX holds a HI/LO-class instruction
- cmd  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO
- rs_val  in  32  rs operand (forwarded)
- rt_val  in  32  rt operand (forwarded)
- flush  in  1  kill the instruction in EX this cycle
- hold  in  1  downstream stall; EX instruction re-presented next cycle
- md_busy  in  1  busy from the muldiv unit
- md_hi, md_lo  in  32 each  HI/LO from the muldiv unit
- md_start  out  1  start to muldiv
- md_we  out  1  write-enable to muldiv
- md_hilo  out  1  1 = write HI, 0 = write LO
- md_op  out  2  operation, encoded with the SIGNED_MUL/UNSIGNED_MUL/SIGNED_DIV/UNSIGNED_DIV macros of muldivop_def.v
- md_d1, md_d2  out  32 each  operands (rs_val, rt_val)
- stall  out  1  freeze IF/ID/EX
- rd_valid  out  1  rd_data is valid this cycle
- rd_data  out  32  MFHI/MFLO result
- div0  out  1  one-cycle pulse on a suppressed divide by zero
- stall_cnt  out  CNT_W  cycles with stall=1, saturating

Behaviour:
- FSM states: IDLE, LAUNCH, RUN; state and stall_cnt are registered.
- Reset (rst high at an edge): state=IDLE, stall_cnt=0.
- While rst is high, md_start=md_we=stall=rd_valid=div0=0 and rd_data=0.
- free = (state==IDLE) | (state==RUN & !md_busy).
  - Early release: the muldiv unit writes HI/LO on the same edge it drops busy.
- act = cmd_valid & !flush.
- stall = act & !free, combinational.
- Issue condition: act & free & !hold. All outputs below are combinational from it.
  - MULT/MULTU/DIV/DIVU: md_start=1, md_op per cmd (MULT→SIGNED_MUL, MULTU→UNSIGNED_MUL, DIV→SIGNED_DIV, DIVU→UNSIGNED_DIV).
  - Divide by zero: if DIV0_SKIP and rt_val==0 for DIV/DIVU, md_start=0 and div0=1.
  - MTHI/MTLO: md_we=1, md_hilo=(cmd==6), md_d1=rs_val.
  - MFHI/MFLO: rd_valid=1, rd_data=md_hi/md_lo. Also asserted when hold=1, since reads are idempotent.
- md_d1/md_d2 always carry rs_val/rt_val. md_op holds its last value when not starting.
- Transitions:
  - Any state → LAUNCH when md_start=1. LAUNCH covers the cycle where busy is not yet visible; stall is asserted there.
  - LAUNCH → RUN unconditionally.
  - RUN → IDLE when md_busy==0 and no new start; a new start goes to LAUNCH.
- LAUNCH with md_busy still 0 is not treated as free.
- md_start and md_we are never asserted together; each instruction causes at most one of them.
- hold=1: no start/we issued, state unchanged by the instruction, stall driven by the free logic only.
- flush=1: instruction ignored (no stall, start, we or rd_valid). An in-flight operation is not aborted and completes normally.
- Reset mid-operation: state returns to IDLE. The muldiv unit is reset by the same rst.
- stall_cnt increments on every edge with stall=1 and saturates at all-ones.

Test Plan:
- MULT rs=7, rt=-3 (0xFFFFFFFD), unit with 5-cycle latency → md_start pulse with md_op=SIGNED_MUL. A following MFLO stalls until busy falls, then returns rd_data=0xFFFFFFEB (-21) and MFHI=0xFFFFFFFF, with stall_cnt equal to the stalled cycles.
- DIVU rs=100, rt=7 issued, then MTHI 0x1234 presented the next cycle → MTHI stalls through LAUNCH/RUN. md_we asserts in the cycle busy drops; a subsequent MFHI reads 0x1234 and MFLO reads 14.
- DIV rt=0 with DIV0_SKIP=1 → no md_start, div0=1 for one cycle, state stays IDLE, an immediate MFLO reads the prior LO with no stall.
- MULTU presented with hold=1 for 3 cycles then hold=0 → exactly one md_start, on the cycle hold drops.
- MULT issued, then flush asserted on a following DIV → DIV produces no start and no stall; MULT result still lands in HI/LO.
- rst asserted during RUN → next cycle state IDLE, stall=0, stall_cnt=0; a new MTLO 0x55 writes immediately.
